// File: rtl/proj_sorter_ctrl_if.sv
// Bundle of the item stream, sorter drive/feedback and result handshake around proj_sorter_ctrl.
// The controller sits on the slave side; the surrounding pipeline (or a bench) takes the master side.
interface proj_sorter_ctrl_if #(
    parameter int INDICES_COUNT = 4,
    parameter int INDICE_LEN    = 8,
    parameter int SIGNATURE_LEN = 32,
    parameter int MAX_ITEMS     = 255
);
    localparam int CNT_W = $clog2(MAX_ITEMS + 1);
    localparam int RES_W = INDICES_COUNT * INDICE_LEN;

    logic                     in_valid;
    logic                     out_ready;
    logic [SIGNATURE_LEN-1:0] in_signature;
    logic [INDICE_LEN-1:0]    in_index;
    logic                     in_last;

    logic [SIGNATURE_LEN-1:0] out_sort_signature;
    logic [INDICE_LEN-1:0]    out_sort_index;
    logic                     out_sort_rst_n;
    logic [RES_W-1:0]         in_sort_smallest_idx;

    logic                     out_valid;
    logic                     in_ready;
    logic [RES_W-1:0]         out_indices;
    logic [CNT_W-1:0]         out_count;
    logic                     out_truncated;

    modport slave (
        input  in_valid, in_signature, in_index, in_last,
        input  in_sort_smallest_idx, in_ready,
        output out_ready, out_sort_signature, out_sort_index, out_sort_rst_n,
        output out_valid, out_indices, out_count, out_truncated
    );

    modport master (
        output in_valid, in_signature, in_index, in_last,
        output in_sort_smallest_idx, in_ready,
        input  out_ready, out_sort_signature, out_sort_index, out_sort_rst_n,
        input  out_valid, out_indices, out_count, out_truncated
    );
endinterface

// File: rtl/proj_sorter_ctrl.sv
// Per-document sequencer for the min-K sorter: clear, feed one document, wait out the
// sorter latency, then hold the K smallest indices for the extender until it accepts them.
module proj_sorter_ctrl #(
    // Defaults mirror proj_pkg (SORTER_EXTENDER_INDICES_COUNT, INDICE_LEN, HASHER_SORTER_SIGNATURE).
    parameter int INDICES_COUNT = 4,
    parameter int INDICE_LEN    = 8,
    parameter int SIGNATURE_LEN = 32,
    parameter int SORT_LAT      = 1,
    parameter int MAX_ITEMS     = 255
) (
    input logic            in_clk,
    input logic            in_rst_n,
    proj_sorter_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_ITEMS + 1);
    localparam int RES_W = INDICES_COUNT * INDICE_LEN;
    localparam int LAT_W = (SORT_LAT > 1) ? $clog2(SORT_LAT) : 1;

    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(MAX_ITEMS - 1);
    localparam logic [LAT_W-1:0] LAT_INIT  = LAT_W'(SORT_LAT - 1);

    typedef enum logic [1:0] {
        S_CLEAR   = 2'd0,
        S_FILL    = 2'd1,
        S_DRAIN   = 2'd2,
        S_PRESENT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               trunc_q, trunc_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [RES_W-1:0]   indices_q, indices_d;

    logic               xfer;
    logic               at_max;
    logic               doc_end;

    logic                     ready_o;
    logic                     valid_o;
    logic                     sort_rst_n_o;
    logic [SIGNATURE_LEN-1:0] sort_sig_o;
    logic [INDICE_LEN-1:0]    sort_idx_o;

    assign xfer    = bus.in_valid && (state_q == S_FILL);
    assign at_max  = (count_q == LAST_SLOT);
    assign doc_end = xfer && (bus.in_last || at_max);

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q <= S_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CLEAR:   state_d = S_FILL;
            S_FILL:    if (doc_end) state_d = S_DRAIN;
            S_DRAIN:   if (lat_q == '0) state_d = S_PRESENT;
            S_PRESENT: if (bus.in_ready) state_d = S_CLEAR;
            default:   state_d = S_CLEAR;
        endcase
    end

    always_comb begin
        ready_o      = (state_q == S_FILL);
        valid_o      = (state_q == S_PRESENT);
        sort_rst_n_o = in_rst_n && (state_q != S_CLEAR);
        // Idle cycles push an all-ones signature, which never wins a strict less-than compare.
        sort_sig_o   = xfer ? bus.in_signature : '1;
        sort_idx_o   = xfer ? bus.in_index : '0;
    end

    // Document bookkeeping: item count, truncation flag, drain countdown, captured result.
    always_comb begin
        count_d   = count_q;
        trunc_d   = trunc_q;
        lat_d     = lat_q;
        indices_d = indices_q;
        case (state_q)
            S_CLEAR: begin
                count_d = '0;
                trunc_d = 1'b0;
            end
            S_FILL: begin
                if (xfer) begin
                    count_d = count_q + CNT_W'(1);
                    if (at_max && !bus.in_last) trunc_d = 1'b1;
                    if (doc_end) lat_d = LAT_INIT;
                end
            end
            S_DRAIN: begin
                if (lat_q == '0) indices_d = bus.in_sort_smallest_idx;
                else             lat_d     = lat_q - LAT_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            count_q   <= '0;
            trunc_q   <= 1'b0;
            lat_q     <= '0;
            indices_q <= '0;
        end else begin
            count_q   <= count_d;
            trunc_q   <= trunc_d;
            lat_q     <= lat_d;
            indices_q <= indices_d;
        end
    end

    assign bus.out_ready          = ready_o;
    assign bus.out_valid          = valid_o;
    assign bus.out_sort_rst_n     = sort_rst_n_o;
    assign bus.out_sort_signature = sort_sig_o;
    assign bus.out_sort_index     = sort_idx_o;
    assign bus.out_indices        = indices_q;
    assign bus.out_count          = count_q;
    assign bus.out_truncated      = trunc_q;
endmodule
